// File: rtl/exec_pkg.sv
// exec_pkg: shared constants and types for the execute stage.
// Opcode map, ALU operation encodings, ALU function codes, branch
// condition codes and the execute-stage FSM state type.
package exec_pkg;

    // Opcodes
    localparam logic [3:0] OP_ADD_0  = 4'd0;
    localparam logic [3:0] OP_ADD_1  = 4'd1;
    localparam logic [3:0] OP_ADD_2  = 4'd2;
    localparam logic [3:0] OP_ALU    = 4'd3;
    localparam logic [3:0] OP_ADD_4  = 4'd4;
    localparam logic [3:0] OP_BRANCH = 4'd5;
    localparam logic [3:0] OP_MUL    = 4'd6;

    // fun_code values selecting the ALU operation for OP_ALU
    localparam logic [3:0] FUN_AND = 4'b0000;
    localparam logic [3:0] FUN_OR  = 4'b0001;
    localparam logic [3:0] FUN_ADD = 4'b0010;
    localparam logic [3:0] FUN_SUB = 4'b0110;
    localparam logic [3:0] FUN_SLT = 4'b0111;
    localparam logic [3:0] FUN_NOR = 4'b1100;

    // fun_code values selecting the branch condition for OP_BRANCH
    localparam logic [3:0] BR_ALWAYS = 4'd0;
    localparam logic [3:0] BR_ZERO   = 4'd1;
    localparam logic [3:0] BR_NZERO  = 4'd2;
    localparam logic [3:0] BR_NEG    = 4'd3;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3,
        ALU_SLT = 3'd4,
        ALU_NOR = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VALID   = 2'd1,
        ST_MUL_RUN = 2'd2
    } state_t;

    // Map an OP_ALU function code to an ALU operation; unknown codes fall back to AND
    function automatic alu_op_t fun_to_alu_op(input logic [3:0] fun);
        alu_op_t op;
        case (fun)
            FUN_AND: op = ALU_AND;
            FUN_OR:  op = ALU_OR;
            FUN_ADD: op = ALU_ADD;
            FUN_SUB: op = ALU_SUB;
            FUN_SLT: op = ALU_SLT;
            FUN_NOR: op = ALU_NOR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu: purely combinational ALU for the execute stage.
// zf and sign always describe (a - b), independent of op, so the branch
// logic can use them whatever operation is selected.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              zf,
    output logic              sign
);

    logic [DATA_W-1:0] diff_s;
    logic              slt_s;

    assign diff_s = a - b;
    assign slt_s  = ($signed(a) < $signed(b));
    assign zf     = (diff_s == {DATA_W{1'b0}});
    assign sign   = diff_s[DATA_W-1];

    // Result select by ALU operation
    always_comb begin
        result = {DATA_W{1'b0}};
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = diff_s;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt_s};
            ALU_NOR: result = ~(a | b);
            default: result = a & b;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// exec_stage: in-order pipeline execute stage.
// Captures one decoded instruction per decode handshake, resolves operand
// forwarding from the M/W stages in the accept cycle, computes ALU result and
// branch decision, and presents them to the memory stage with valid/ready.
// Optional feature macro: EXEC_MUL_EN enables the iterative shift-add
// multiplier (opcode 6, MUL_RUN state); without it opcode 6 is illegal.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [3:0]        ins_code,
    input  logic [3:0]        fun_code,
    input  logic [REG_AW-1:0] src_a,
    input  logic [REG_AW-1:0] src_b,
    input  logic [REG_AW-1:0] dst,
    input  logic [DATA_W-1:0] reg_a,
    input  logic [DATA_W-1:0] reg_b,
    input  logic [DATA_W-1:0] val_c,
    input  logic              use_imm_a,
    input  logic              zero_b,
    input  logic              write_reg,
    input  logic              write_alu_mem,
    input  logic [PC_W-1:0]   incre_pc,
    input  logic              fwd_m_we,
    input  logic [REG_AW-1:0] fwd_m_dst,
    input  logic [DATA_W-1:0] fwd_m_data,
    input  logic              fwd_w_we,
    input  logic [REG_AW-1:0] fwd_w_dst,
    input  logic [DATA_W-1:0] fwd_w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        ins_code_o,
    output logic [REG_AW-1:0] dst_o,
    output logic              write_reg_o,
    output logic              write_alu_mem_o,
    output logic [DATA_W-1:0] val_c_o,
    output logic [PC_W-1:0]   incre_pc_o,
    output logic              jmp_flag,
    output logic              error
);

    state_t            state_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] alu_out_r;
    logic [3:0]        ins_code_r;
    logic [REG_AW-1:0] dst_r;
    logic              write_reg_r;
    logic              write_alu_mem_r;
    logic [DATA_W-1:0] val_c_r;
    logic [PC_W-1:0]   incre_pc_r;
    logic              jmp_r;
    logic              error_r;

    logic              accept_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    alu_op_t           alu_op_s;
    logic              legal_s;
    logic              is_mul_s;
    logic              bubble_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              zf_s;
    logic              sign_s;
    logic              taken_s;

    assign in_ready = (state_r == ST_IDLE) || ((state_r == ST_VALID) && out_ready);
    assign accept_s = in_valid && in_ready;
    // Squashed or illegal instructions still occupy the output slot, but as a no-op
    assign bubble_s = flush || !legal_s;

    // Operand A: immediate, then M-stage, then W-stage forwarding, then register file
    always_comb begin
        op_a_s = reg_a;
        if (use_imm_a) begin
            op_a_s = val_c;
        end else if (fwd_m_we && (fwd_m_dst == src_a) && (src_a != {REG_AW{1'b0}})) begin
            op_a_s = fwd_m_data;
        end else if (fwd_w_we && (fwd_w_dst == src_a) && (src_a != {REG_AW{1'b0}})) begin
            op_a_s = fwd_w_data;
        end else begin
            op_a_s = reg_a;
        end
    end

    // Operand B: forced zero, then M-stage, then W-stage forwarding, then register file
    always_comb begin
        op_b_s = reg_b;
        if (zero_b) begin
            op_b_s = {DATA_W{1'b0}};
        end else if (fwd_m_we && (fwd_m_dst == src_b) && (src_b != {REG_AW{1'b0}})) begin
            op_b_s = fwd_m_data;
        end else if (fwd_w_we && (fwd_w_dst == src_b) && (src_b != {REG_AW{1'b0}})) begin
            op_b_s = fwd_w_data;
        end else begin
            op_b_s = reg_b;
        end
    end

    // Opcode decode: ALU operation, legality and multiply detection
    always_comb begin
        alu_op_s = ALU_ADD;
        legal_s  = 1'b1;
        is_mul_s = 1'b0;
        case (ins_code)
            OP_ADD_0, OP_ADD_1, OP_ADD_2, OP_ADD_4: alu_op_s = ALU_ADD;
            OP_ALU:    alu_op_s = fun_to_alu_op(fun_code);
            OP_BRANCH: alu_op_s = ALU_SUB;
`ifdef EXEC_MUL_EN
            OP_MUL:    is_mul_s = 1'b1;
`else
            OP_MUL:    legal_s  = 1'b0;
`endif
            default:   legal_s  = 1'b0;
        endcase
    end

    exec_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (op_a_s),
        .b      (op_b_s),
        .op     (alu_op_s),
        .result (alu_result_s),
        .zf     (zf_s),
        .sign   (sign_s)
    );

    // Branch decision from the zero/sign flags of (A - B)
    always_comb begin
        taken_s = 1'b0;
        if (ins_code == OP_BRANCH) begin
            case (fun_code)
                BR_ALWAYS: taken_s = 1'b1;
                BR_ZERO:   taken_s = zf_s;
                BR_NZERO:  taken_s = !zf_s;
                BR_NEG:    taken_s = sign_s;
                default:   taken_s = 1'b0;
            endcase
        end else begin
            taken_s = 1'b0;
        end
    end

`ifdef EXEC_MUL_EN
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] acc_next_s;
    logic              mul_done_s;

    // Only the low DATA_W product bits are kept, so the accumulator never widens
    assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {DATA_W{1'b0}});
    assign mul_done_s = (cnt_r == LAST_CNT);

    // Shift-add multiplier datapath: load on MUL accept, one step per MUL_RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {DATA_W{1'b0}};
            mplier_r <= {DATA_W{1'b0}};
            acc_r    <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (accept_s && is_mul_s && !flush) begin
            mcand_r  <= op_a_s;
            mplier_r <= op_b_s;
            acc_r    <= {DATA_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == ST_MUL_RUN) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= acc_next_s;
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
        end
    end
`endif

    // Control FSM, output pipeline registers and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            out_valid_r     <= 1'b0;
            alu_out_r       <= {DATA_W{1'b0}};
            ins_code_r      <= 4'd0;
            dst_r           <= {REG_AW{1'b0}};
            write_reg_r     <= 1'b0;
            write_alu_mem_r <= 1'b0;
            val_c_r         <= {DATA_W{1'b0}};
            incre_pc_r      <= {PC_W{1'b0}};
            jmp_r           <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_VALID: begin
                    if (accept_s) begin
                        ins_code_r      <= bubble_s ? 4'd0 : ins_code;
                        write_reg_r     <= bubble_s ? 1'b0 : write_reg;
                        write_alu_mem_r <= bubble_s ? 1'b0 : write_alu_mem;
                        jmp_r           <= bubble_s ? 1'b0 : taken_s;
                        alu_out_r       <= (bubble_s || is_mul_s) ? {DATA_W{1'b0}} : alu_result_s;
                        dst_r           <= dst;
                        val_c_r         <= val_c;
                        incre_pc_r      <= incre_pc;
                        // A flushed MUL is just a bubble and never starts iterating
                        if (is_mul_s && !flush) begin
                            state_r     <= ST_MUL_RUN;
                            out_valid_r <= 1'b0;
                        end else begin
                            state_r     <= ST_VALID;
                            out_valid_r <= 1'b1;
                        end
                    end else if ((state_r == ST_VALID) && out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= state_r;
                        out_valid_r <= out_valid_r;
                    end
                end
                ST_MUL_RUN: begin
`ifdef EXEC_MUL_EN
                    if (flush) begin
                        state_r         <= ST_IDLE;
                        out_valid_r     <= 1'b0;
                        ins_code_r      <= 4'd0;
                        write_reg_r     <= 1'b0;
                        write_alu_mem_r <= 1'b0;
                    end else if (mul_done_s) begin
                        state_r     <= ST_VALID;
                        out_valid_r <= 1'b1;
                        alu_out_r   <= acc_next_s;
                    end else begin
                        state_r     <= ST_MUL_RUN;
                        out_valid_r <= 1'b0;
                    end
`else
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
`endif
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase

            // Wrong-path (flushed) instructions do not raise the error flag
            if (accept_s && !flush && !legal_s) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
        end
    end

    assign out_valid       = out_valid_r;
    assign alu_out         = alu_out_r;
    assign ins_code_o      = ins_code_r;
    assign dst_o           = dst_r;
    assign write_reg_o     = write_reg_r;
    assign write_alu_mem_o = write_alu_mem_r;
    assign val_c_o         = val_c_r;
    assign incre_pc_o      = incre_pc_r;
    assign jmp_flag        = jmp_r;
    assign error           = error_r;

endmodule

// File: doc/exec_stage.md
# exec_stage

Parametrised execute stage for the in-order integer pipeline, sitting between decode and memory. It captures one decoded instruction per handshake and resolves operand forwarding internally by comparing source register addresses against the M/W destinations. It computes the ALU result and branch decision, and adds an optional multi-cycle iterative multiplier. Valid/ready handshakes on both sides let it stall decode and absorb memory-stage back-pressure.

## Interface
- DATA_W, 8, datapath width (operands, ALU, val_c)
- REG_AW, 4, register address width
- PC_W, 8, program-counter width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  decode handshake
- flush  in  1  squash the instruction being accepted and any in-flight MUL
- ins_code, fun_code  in  4 / 4  opcode, function code
- src_a, src_b, dst  in  REG_AW  source and destination register addresses
- reg_a, reg_b  in  DATA_W  register-file read data
- val_c  in  DATA_W  immediate
- use_imm_a, zero_b  in  1 / 1  A := val_c; B := 0 (both override forwarding)
- write_reg, write_alu_mem, incre_pc  in  1 / 1 / PC_W  passed through
- fwd_m_we, fwd_m_dst, fwd_m_data  in  1 / REG_AW / DATA_W  memory-stage writeback
- fwd_w_we, fwd_w_dst, fwd_w_data  in  1 / REG_AW / DATA_W  writeback-stage writeback
- out_valid / out_ready  out / in  1 / 1  memory-stage handshake
- alu_out  out  DATA_W  result
- ins_code_o, dst_o, write_reg_o, write_alu_mem_o, val_c_o, incre_pc_o  out  pipelined copies
- jmp_flag  out  1  branch taken; qualified by out_valid
- error  out  1  sticky illegal-opcode flag

## Operation
- Accept when in_valid && in_ready. Operands, forwarding and decode all resolve in the accept cycle and are registered.
- Forwarding per source: use_imm_a/zero_b override first. Otherwise M matches if fwd_m_we && fwd_m_dst==src && src!=0. W matches under the same conditions. M has priority over W, and W over reg_a/reg_b. Register 0 always reads as the register-file value.
- Opcode to ALU op:
  - 0, 1, 2, 4: ADD
  - 3: fun_code (AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100; other fun_code → AND, no error)
  - 5: SUB, the compare/branch opcode
  - 6: MUL (see Configuration)
  - 7–15: illegal
- Arithmetic: modulo 2^DATA_W. SLT is signed and returns 0 or 1. MUL returns the low DATA_W bits of the product.
- Branch on opcode 5: zf = (A−B)==0. fun_code 0 = always, 1 = zf, 2 = !zf, 3 = sign of (A−B); otherwise not taken. jmp_flag is 0 for all other opcodes.
- Illegal opcode: error set (sticky until reset). The output is a bubble: ins_code_o=0, write_reg_o=0, write_alu_mem_o=0.
- flush asserted in an accept cycle: the output is a bubble. flush during MUL_RUN aborts the multiply, and the FSM goes to IDLE (with flush+accept in the same cycle, the accepted bubble takes priority → VALID).
- FSM:
  - IDLE: no output held.
  - VALID: output held until out_ready.
  - MUL_RUN: iterating.
  - Transitions: IDLE/VALID → VALID on a single-cycle accept; → MUL_RUN on a MUL accept. VALID → IDLE on out_ready with no accept. MUL_RUN → VALID after DATA_W iterations.
- in_ready = (state==IDLE) || (state==VALID && out_ready).

## Timing
- Reset values: all outputs 0, state IDLE, error 0, in_ready 1.
- Single-cycle ops: result valid the cycle after accept. Full throughput of 1 instruction/cycle under out_ready=1.
- MUL: one shift-add step per cycle. out_valid rises DATA_W+1 cycles after accept. in_ready=0 throughout MUL_RUN.
- Outputs are stable while out_valid && !out_ready.
- Forwarding inputs are sampled only in the accept cycle. Changes during MUL_RUN are ignored.
- rst_n low at any point, including mid-MUL: immediate return to reset values.

## Configuration
- EXEC_MUL_EN defined: iterative multiplier and MUL_RUN state are present, and opcode 6 is legal.
- EXEC_MUL_EN undefined: no multiplier logic. Opcode 6 is illegal (error, bubble), and MUL_RUN is unreachable.

## Structure
- Package exec_pkg holds the opcode constants, the ALU-op encodings, the branch-condition codes and the FSM state typedef.
- Sub-module exec_alu is purely combinational: A, B, op → result, zf, sign.
- Forwarding, FSM, multiplier and pipeline registers live in exec_stage.

## Test plan
- Opcode 3, fun_code SUB, reg_a=5, reg_b=9, no forwarding → alu_out=0xFC, out_valid one cycle after accept.
- src_a=3, fwd_m_dst=3 (data 0x11), fwd_w_dst=3 (data 0x22), both we=1, opcode 0, zero_b=1 → alu_out=0x11. Repeat with src_a=0 → alu_out=reg_a.
- Opcode 5, fun_code 1, A=B=0x40 → jmp_flag=1. fun_code 3, A=1, B=2 → jmp_flag=1. fun_code 2, A=B → jmp_flag=0.
- EXEC_MUL_EN defined, MUL 13×11 → alu_out=0x8F after 9 cycles with in_ready=0 throughout. Assert flush at iteration 4 → IDLE, no out_valid. Undefined: error=1, write_reg_o=0.
- out_ready held 0 for 3 cycles with in_valid=1 → outputs frozen, in_ready=0, no instruction lost or duplicated.
- Opcode 9 → error=1 and stays 1. Drop rst_n mid-stream → all outputs 0 asynchronously.
